lsu: RTL and testbench
======================

# lsu

Load/store unit for the execute-to-memory boundary of the CPU core. It consumes the effective address produced by the ALU's `a + b` operation (op 0, add) together with the store operand and access type. It performs one aligned byte, halfword or word access over a simple valid/ready memory bus, and returns sign- or zero-extended load data to writeback. The unit handles one access at a time; the core stalls on `req_ready`.

## Interface
Parameters:
- none; data and address widths are fixed at 32 bits.

Ports:
- `clk`  in  1  core clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  access request from the execute stage.
- `req_ready`  out  1  unit can accept a request; high only in IDLE.
- `addr`  in  32  effective byte address, taken from the ALU `dout`.
- `wdata`  in  32  store operand (rs2 value).
- `is_store`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access type.
  - Loads: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
  - Stores: 0 SB, 1 SH, 2 SW.
- `mem_valid`  out  1  bus request.
- `mem_ready`  in  1  bus completion; may be high in the same cycle `mem_valid` first rises.
- `mem_addr`  out  32  word address, `{addr[31:2], 2'b00}`.
- `mem_wdata`  out  32  lane-aligned store data.
- `mem_wstrb`  out  4  byte enables; `4'b0000` for loads.
- `mem_rdata`  in  32  read data; valid in the `mem_valid && mem_ready` cycle.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `done`: misaligned or illegal access, no bus cycle was issued.
- `rdata`  out  32  load result, valid while `done` is high; 0 for stores and errors.

## Operation
- **States:** IDLE, BUS, RESP.
- **IDLE:**
  - `req_ready` = 1.
  - On `req_valid`, latch `addr`, `wdata`, `is_store` and `funct3`, then check legality.
  - Legal → BUS.
  - Illegal → RESP with `err` set.
- **Illegal conditions:**
  - any `funct3` outside the list above (loads 3/6/7; stores 3–7);
  - halfword access with `addr[0]` = 1;
  - word access with `addr[1:0]` ≠ 0.
- **BUS:**
  - `mem_valid` = 1.
  - `mem_addr`, `mem_wdata` and `mem_wstrb` are registered and held stable until `mem_ready`.
  - On `mem_ready`, capture the extracted load data → RESP.
- **RESP:**
  - `done` = 1 for exactly one cycle, then → IDLE.
  - `req_ready` = 0 in RESP, so there is no back-to-back accept in the same cycle.
- **Store lanes:**
  - SB: `mem_wdata` = byte replicated ×4; `mem_wstrb` = `1 << addr[1:0]`.
  - SH: `mem_wdata` = halfword replicated ×2; `mem_wstrb` = `4'b0011` (`addr[1]` = 0) or `4'b1100` (`addr[1]` = 1).
  - SW: `mem_wdata` = `wdata`; `mem_wstrb` = `4'b1111`.
- **Load extraction:**
  - Shift `mem_rdata` right by `8*addr[1:0]`.
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes through unchanged.
- **Unused inputs:** `mem_rdata` is ignored for stores; `wdata` is ignored for loads.

## Timing
- **Reset:** `reset` high at an edge forces state IDLE and clears every output:
  - `mem_valid` = 0, `mem_addr` = 0, `mem_wdata` = 0, `mem_wstrb` = 0;
  - `done` = 0, `err` = 0, `rdata` = 0.
  - `req_ready` = 1 from the first cycle after reset.
- **Legal access:** request accepted at edge t.
  - `mem_valid` is high from cycle t+1.
  - With `mem_ready` at cycle t+1+w (w ≥ 0 wait cycles), `done` is high in cycle t+2+w.
  - Next accept possible at edge t+3+w.
  - Zero-wait load: 3 cycles accept-to-accept.
- **Illegal access:** `done` and `err` are high in cycle t+1; `mem_valid` never rises.
- **`mem_valid`:** deasserts the cycle after the `mem_ready` handshake; never two handshakes per request.
- **Mid-operation reset:** reset in BUS drops `mem_valid` at the next edge without waiting for `mem_ready`. The outstanding access is abandoned and `done` is not produced.
- **Output registering:** `done`, `err` and `rdata` are registered. `req_ready` is decoded from state only and has no combinational path from `req_valid`.

## Test plan
- **Reset:** assert `reset` for 2 cycles during BUS → `mem_valid` = 0 and `done` = 0 next cycle; `req_ready` = 1 after release.
- **LB sign extension:** LB at `addr` = `0x1003`, `mem_rdata` = `0x80FF_0000`, zero wait.
  - `mem_addr` = `0x1000`, `mem_wstrb` = 0.
  - `done` 2 cycles after accept, `rdata` = `0xFFFF_FF80`.
  - LBU at the same address → `rdata` = `0x0000_0080`.
- **SH, upper half:** SH at `addr` = `0x2002`, `wdata` = `0x1234_ABCD`.
  - `mem_wdata` = `0xABCD_ABCD`, `mem_wstrb` = `4'b1100`, `mem_addr` = `0x2000`.
  - `rdata` = 0 with `done`.
- **Misaligned:** LW at `0x3001` → `done` = 1, `err` = 1 one cycle after accept; `mem_valid` stays 0 throughout. Same for LH at `0x3003`, and for `funct3` = 3 with `is_store` = 1.
- **Wait states:** LW at `0x4000` with `mem_ready` delayed 3 cycles.
  - `mem_valid`, `mem_addr` and `mem_wstrb` are stable all 4 cycles.
  - `done` at accept+5, `rdata` = `mem_rdata` (`0xDEAD_BEEF`).
- **Back-to-back:** hold `req_valid` high with SW then LH (`0x5002`, `mem_rdata` = `0x8001_0000`).
  - Exactly two bus handshakes occur.
  - Accepts are 3 cycles apart under zero wait.
  - Second `rdata` = `0xFFFF_8001`.

Source files
------------

// File: rtl/lsu.sv
// lsu -- load/store unit at the execute-to-memory boundary.
//
// Accepts one aligned byte/halfword/word access at a time, issues it on a
// valid/ready memory bus and returns sign- or zero-extended load data.
// Misaligned or unsupported accesses complete immediately with err set and
// never touch the bus.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   req_valid/req_ready   request handshake from execute (ready only in IDLE)
//   addr, wdata           effective byte address, store operand
//   is_store, funct3      access direction and type (LB/LH/LW/LBU/LHU, SB/SH/SW)
//   mem_valid/mem_ready   bus request / completion
//   mem_addr              word-aligned bus address
//   mem_wdata, mem_wstrb  lane-replicated store data and byte enables
//   mem_rdata             bus read data
//   done, err, rdata      one-cycle completion pulse, error flag, load result
module lsu (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_funct3;
    logic        r_is_store;

    logic        w_legal;
    logic [31:0] w_st_data;
    logic [3:0]  w_st_strb;
    logic [31:0] w_shifted;
    logic [31:0] w_load;

    // Decoded from state only, so no combinational path from req_valid.
    assign req_ready = (r_state == S_IDLE);

    // Legality of the incoming request: type must exist for the direction
    // and halfword/word accesses must be naturally aligned.
    always_comb begin
        w_legal = 1'b0;
        case (funct3)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~addr[0];
            3'd2:    w_legal = (addr[1:0] == 2'b00);
            3'd4:    w_legal = ~is_store;
            3'd5:    w_legal = ~is_store & ~addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    // Store data is replicated across all lanes; the strobe picks the lane.
    always_comb begin
        w_st_data = wdata;
        w_st_strb = 4'b1111;
        case (funct3[1:0])
            2'd0: begin
                w_st_data = {4{wdata[7:0]}};
                w_st_strb = 4'b0001 << addr[1:0];
            end
            2'd1: begin
                w_st_data = {2{wdata[15:0]}};
                w_st_strb = addr[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
        if (!is_store) begin
            w_st_data = '0;
            w_st_strb = '0;
        end
    end

    // Bring the addressed byte/halfword down to bit 0, then extend.
    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'd0:    w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'd1:    w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'd4:    w_load = {24'd0, w_shifted[7:0]};
            3'd5:    w_load = {16'd0, w_shifted[15:0]};
            default: w_load = w_shifted;
        endcase
        if (r_is_store) begin
            w_load = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_off      <= '0;
            r_funct3   <= '0;
            r_is_store <= 1'b0;
            mem_valid  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_off      <= addr[1:0];
                        r_funct3   <= funct3;
                        r_is_store <= is_store;
                        if (w_legal) begin
                            r_state   <= S_BUS;
                            mem_valid <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= w_st_data;
                            mem_wstrb <= w_st_strb;
                        end else begin
                            r_state <= S_RESP;
                            done    <= 1'b1;
                            err     <= 1'b1;
                            rdata   <= '0;
                        end
                    end
                end
                S_BUS: begin
                    if (mem_ready) begin
                        r_state   <= S_RESP;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        err       <= 1'b0;
                        rdata     <= w_load;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    rdata   <= '0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata = '0;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    lsu dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .addr      (addr),
        .wdata     (wdata),
        .is_store  (is_store),
        .funct3    (funct3),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned lat;   // cycle of done relative to accept edge
    } exp_t;

    exp_t        exp_q[$];
    int unsigned acc_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned hs_cnt = 0;
    int unsigned mv_cnt = 0;

    // Bus responder: ready after cfg_wait wait cycles, driven on negedge.
    int unsigned cfg_wait = 0;
    logic [31:0] cfg_rdata = '0;
    bit          resp_en = 1'b1;
    int unsigned wcnt = 0;

    always @(negedge clk) begin
        mem_rdata = cfg_rdata;
        if (mem_valid && resp_en) begin
            mem_ready = (wcnt == cfg_wait);
            wcnt++;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Edge counter and event monitors; cyc equals the index of the last edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) acc_q.push_back(cyc + 1);
        if (mem_valid && mem_ready) hs_cnt <= hs_cnt + 1;
        if (mem_valid) mv_cnt <= mv_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [31:0] a, input logic [31:0] wd,
                        input logic st, input logic [2:0] f3);
        int unsigned n = 0;
        @(negedge clk);
        addr = a; wdata = wd; is_store = st; funct3 = f3; req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL send_accept req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (done) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            mem_wstrb !== 4'h0 || done !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b addr=%h wdata=%h wstrb=%h done=%b err=%b rdata=%h required all zero",
                     mem_valid, mem_addr, mem_wdata, mem_wstrb, done, err, rdata);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready got=%b required 1", req_ready);
        end
        // Reset while a store is outstanding on the bus.
        resp_en = 1'b0;
        acc_q.delete();
        send(32'h0000_0104, 32'hCAFE_F00D, 1'b1, 3'd2);
        checks++;
        if (mem_valid !== 1'b1) begin
            errors++; $display("FAIL midreset_pre valid=%b required 1", mem_valid);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || done !== 1'b0 || mem_wdata !== 32'h0 || mem_wstrb !== 4'h0) begin
            errors++;
            $display("FAIL midreset_drop valid=%b done=%b wdata=%h wstrb=%h required 0/0/0/0",
                     mem_valid, done, mem_wdata, mem_wstrb);
        end
        @(negedge clk);
        reset = 1'b0;
        resp_en = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || done !== 1'b0 || mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_after ready=%b done=%b valid=%b required 1/0/0", req_ready, done, mem_valid);
        end
    endtask

    task automatic test_lb();
        bit ok;
        exp_t e;
        int unsigned lat;
        cfg_wait = 0;
        cfg_rdata = 32'h80FF_0000;
        for (int k = 0; k < 2; k++) begin
            acc_q.delete();
            if (k == 0) exp_q.push_back('{32'hFFFF_FF80, 1'b0, 2});
            else        exp_q.push_back('{32'h0000_0080, 1'b0, 2});
            send(32'h0000_1003, 32'h0, 1'b0, (k == 0) ? 3'd0 : 3'd4);
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_1000 || mem_wstrb !== 4'h0) begin
                errors++;
                $display("FAIL lb_bus valid=%b addr=%h wstrb=%h required 1/00001000/0", mem_valid, mem_addr, mem_wstrb);
            end
            wait_done(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || acc_q.size() == 0) begin
                errors++; $display("FAIL lb_done k=%0d timeout", k);
            end else begin
                lat = cyc + 1 - acc_q[0];
                if (rdata !== e.rdata || err !== e.err || lat != e.lat) begin
                    errors++;
                    $display("FAIL lb_result k=%0d rdata=%h err=%b lat=%0d required %h/%b/%0d",
                             k, rdata, err, lat, e.rdata, e.err, e.lat);
                end
            end
        end
    endtask

    task automatic test_sh();
        bit ok;
        exp_t e;
        acc_q.delete();
        exp_q.push_back('{32'h0, 1'b0, 2});
        send(32'h0000_2002, 32'h1234_ABCD, 1'b1, 3'd1);
        checks++;
        if (mem_wdata !== 32'hABCD_ABCD || mem_wstrb !== 4'b1100 || mem_addr !== 32'h0000_2000) begin
            errors++;
            $display("FAIL sh_bus wdata=%h wstrb=%b addr=%h required abcdabcd/1100/00002000", mem_wdata, mem_wstrb, mem_addr);
        end
        wait_done(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || rdata !== e.rdata || err !== e.err) begin
            errors++;
            $display("FAIL sh_done ok=%b rdata=%h err=%b required 1/%h/%b", ok, rdata, err, e.rdata, e.err);
        end
    endtask

    task automatic test_store_lanes();
        bit ok;
        exp_t e;
        logic [31:0] wd;
        logic [3:0]  es;
        for (int unsigned off = 0; off < 4; off++) begin
            wd = $urandom;
            es = 4'b0001 << off;
            exp_q.push_back('{32'h0, 1'b0, 2});
            send(32'h0000_0600 + off, wd, 1'b1, 3'd0);
            checks++;
            if (mem_wstrb !== es || mem_wdata !== {wd[7:0], wd[7:0], wd[7:0], wd[7:0]} ||
                mem_addr !== 32'h0000_0600) begin
                errors++;
                $display("FAIL sb_lane off=%0d wstrb=%b wdata=%h addr=%h required %b/%h/00000600",
                         off, mem_wstrb, mem_wdata, mem_addr, es, {wd[7:0], wd[7:0], wd[7:0], wd[7:0]});
            end
            wait_done(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || rdata !== e.rdata || err !== e.err) begin
                errors++;
                $display("FAIL sb_done off=%0d ok=%b rdata=%h err=%b required 1/%h/%b", off, ok, rdata, err, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        exp_t e;
        int unsigned mv0, lat;
        logic [31:0] a;
        logic        st;
        logic [2:0]  f3;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       begin a = 32'h0000_3001; st = 1'b0; f3 = 3'd2; end
                1:       begin a = 32'h0000_3003; st = 1'b0; f3 = 3'd1; end
                2:       begin a = 32'h0000_3000; st = 1'b1; f3 = 3'd3; end
                default: begin a = 32'h0000_3000; st = 1'b0; f3 = 3'd6; end
            endcase
            acc_q.delete();
            mv0 = mv_cnt;
            exp_q.push_back('{32'h0, 1'b1, 1});
            send(a, 32'hFFFF_FFFF, st, f3);
            wait_done(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || acc_q.size() == 0) begin
                errors++; $display("FAIL misaligned_done k=%0d timeout", k);
            end else begin
                lat = cyc + 1 - acc_q[0];
                if (err !== e.err || rdata !== e.rdata || lat != e.lat) begin
                    errors++;
                    $display("FAIL misaligned k=%0d err=%b rdata=%h lat=%0d required %b/%h/%0d",
                             k, err, rdata, lat, e.err, e.rdata, e.lat);
                end
            end
            repeat (2) @(negedge clk);
            checks++;
            if (mv_cnt != mv0) begin
                errors++; $display("FAIL misaligned_bus k=%0d mem_valid cycles=%0d required 0", k, mv_cnt - mv0);
            end
        end
    endtask

    task automatic test_wait();
        bit ok;
        exp_t e;
        int unsigned lat;
        acc_q.delete();
        cfg_wait = 3;
        cfg_rdata = 32'hDEAD_BEEF;
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 5});
        send(32'h0000_4000, 32'h0, 1'b0, 3'd2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_4000 || mem_wstrb !== 4'h0 || done !== 1'b0) begin
                errors++;
                $display("FAIL wait_stable i=%0d valid=%b addr=%h wstrb=%h done=%b required 1/00004000/0/0",
                         i, mem_valid, mem_addr, mem_wstrb, done);
            end
            @(negedge clk);
        end
        wait_done(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || acc_q.size() == 0) begin
            errors++; $display("FAIL wait_done timeout");
        end else begin
            lat = cyc + 1 - acc_q[0];
            if (rdata !== e.rdata || err !== e.err || lat != e.lat) begin
                errors++;
                $display("FAIL wait_result rdata=%h err=%b lat=%0d required %h/%b/%0d", rdata, err, lat, e.rdata, e.err, e.lat);
            end
        end
        cfg_wait = 0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int unsigned hs0, got;
        bit released;
        got = 0;
        released = 1'b0;
        acc_q.delete();
        cfg_wait = 0;
        cfg_rdata = 32'h8001_0000;
        hs0 = hs_cnt;
        @(negedge clk);
        addr = 32'h0000_5000; wdata = 32'h1122_3344; is_store = 1'b1; funct3 = 3'd2; req_valid = 1'b1;
        exp_q.push_back('{32'h0, 1'b0, 2});
        @(negedge clk);
        checks++;
        if (acc_q.size() != 1 || mem_wdata !== 32'h1122_3344 || mem_wstrb !== 4'b1111) begin
            errors++;
            $display("FAIL b2b_sw accepts=%0d wdata=%h wstrb=%b required 1/11223344/1111", acc_q.size(), mem_wdata, mem_wstrb);
        end
        addr = 32'h0000_5002; is_store = 1'b0; funct3 = 3'd1;
        exp_q.push_back('{32'hFFFF_8001, 1'b0, 2});
        for (int i = 0; i < 40 && got < 2; i++) begin
            if (acc_q.size() >= 2 && !released) begin
                req_valid = 1'b0;
                released = 1'b1;
            end
            if (done) begin
                e = exp_q.pop_front();
                checks++;
                if (rdata !== e.rdata || err !== e.err) begin
                    errors++;
                    $display("FAIL b2b_result n=%0d rdata=%h err=%b required %h/%b", got, rdata, err, e.rdata, e.err);
                end
                got++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (got != 2 || acc_q.size() != 2) begin
            errors++; $display("FAIL b2b_count dones=%0d accepts=%0d required 2/2", got, acc_q.size());
        end else if (acc_q[1] - acc_q[0] != 3 || hs_cnt - hs0 != 2) begin
            errors++;
            $display("FAIL b2b_timing accept_gap=%0d handshakes=%0d required 3/2", acc_q[1] - acc_q[0], hs_cnt - hs0);
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_store_lanes();
        test_misaligned();
        test_wait();
        test_back_to_back();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
